// File: rtl/reg_dump_unit.sv
// Register-file snapshot streamer: reads every architectural register in turn and emits it as a valid/ready beat.
// Optional build macro DUMP_CHECKSUM_EN appends an XOR checksum beat after the last register.
module reg_dump_unit #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              stall_req,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_ARM  | one cycle for the core to reach its stall point
  // S_LOAD | read port addressed with idx, beat captured at the edge
  // S_SEND | beat presented until accepted
  // S_DONE | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_LOAD, S_SEND, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_idx;
  logic [DATA_W-1:0]   r_out_data;
  logic [ADDR_W-1:0]   r_out_addr;
  logic                r_out_last;
  logic                w_hs;
  logic                w_last_idx;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   r_xor;
`endif

  assign w_hs       = (r_state == S_SEND) && out_ready;
  assign w_last_idx = (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start) w_next = S_ARM;
        S_ARM:  w_next = S_LOAD;
        S_LOAD: w_next = S_SEND;
        S_SEND: begin
          if (w_hs) begin
            if (r_out_last) w_next = S_DONE;
`ifdef DUMP_CHECKSUM_EN
            // checksum beat is loaded directly into the output registers
            else if (w_last_idx) w_next = S_SEND;
`endif
            else w_next = S_LOAD;
          end
        end
        S_DONE: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_out_data <= '0;
      r_out_addr <= '0;
      r_out_last <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      r_xor      <= '0;
`endif
    end else if (abort) begin
      r_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) r_idx <= '0;
`ifdef DUMP_CHECKSUM_EN
        S_ARM:  r_xor <= '0;
`endif
        S_LOAD: begin
          r_out_data <= rd_data;
          r_out_addr <= r_idx;
`ifdef DUMP_CHECKSUM_EN
          r_out_last <= 1'b0;
`else
          r_out_last <= w_last_idx;
`endif
        end
        S_SEND: begin
          if (w_hs && !r_out_last) begin
`ifdef DUMP_CHECKSUM_EN
            r_xor <= r_xor ^ r_out_data;
            if (w_last_idx) begin
              r_out_data <= r_xor ^ r_out_data;
              r_out_addr <= '0;
              r_out_last <= 1'b1;
            end else begin
              r_idx <= r_idx + ADDR_W'(1);
            end
`else
            r_idx <= r_idx + ADDR_W'(1);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign stall_req = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign out_valid = (r_state == S_SEND);
  assign rd_addr   = r_idx;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: full dumps, back-pressure, abort, ignored restart, mid-dump reset.
// Define DUMP_CHECKSUM_EN for both files to exercise the checksum beat.
module tb_reg_dump_unit;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef DUMP_CHECKSUM_EN
  localparam int NB = NR + 1;
`else
  localparam int NB = NR;
`endif

  logic          clk, rst_n, start, abort;
  logic          stall_req, busy, done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;

  logic [DW-1:0] regs [NR];
  logic [31:0]   q_data [$];
  logic [31:0]   q_addr [$];
  logic [31:0]   q_last [$];
  int            n_vec = 0;
  int            n_err = 0;

  assign rd_data = regs[rd_addr];

  reg_dump_unit #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .stall_req(stall_req), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " busy"},      32'(busy),      32'd0);
    chk({tag, " stall_req"}, 32'(stall_req), 32'd0);
    chk({tag, " done"},      32'(done),      32'd0);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " rd_addr"},   32'(rd_addr),   32'd0);
  endtask

  // Expected beat k comes straight from the preloaded register table.
  task automatic chk_beats(input string tag);
    logic [31:0] x;
    logic [31:0] ed, ea, el;
    int n;
    x = '0;
    for (int i = 0; i < NR; i++) x = x ^ regs[i];
    chk({tag, " beat count"}, 32'(q_data.size()), 32'(NB));
    n = (q_data.size() < NB) ? q_data.size() : NB;
    for (int k = 0; k < n; k++) begin
      ed = (k < NR) ? regs[k] : x;
      ea = (k < NR) ? 32'(k) : 32'd0;
`ifdef DUMP_CHECKSUM_EN
      el = 32'(k == NR);
`else
      el = 32'(k == NR - 1);
`endif
      chk($sformatf("%s beat%0d data", tag, k), q_data[k], ed);
      chk($sformatf("%s beat%0d addr", tag, k), q_addr[k], ea);
      chk($sformatf("%s beat%0d last", tag, k), q_last[k], el);
    end
  endtask

  // mode 0: ready always high; mode 1: ready pattern 0,0,1. restart_at>=0 re-pulses start on that beat.
  task automatic run_dump(input int mode, input int restart_at, input string tag);
    int cyc, first_v, hs_cyc, done_cyc, stall_bad, unstable, extra_done, extra_busy;
    logic held;
    logic [31:0] hd, ha, hl;
    q_data.delete(); q_addr.delete(); q_last.delete();
    held = 1'b0; hd = '0; ha = '0; hl = '0;
    first_v = -1; hs_cyc = -1; done_cyc = -1; stall_bad = 0; unstable = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc < 3000) begin
      if (!stall_req || !busy) stall_bad++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (held && (!out_valid || out_data !== hd || 32'(out_addr) !== ha || 32'(out_last) !== hl))
        unstable++;
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 2);
      start = (restart_at >= 0) && out_valid && (32'(out_addr) == 32'(restart_at));
      held = 1'b0;
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_addr.push_back(32'(out_addr));
        q_last.push_back(32'(out_last));
        hs_cyc = cyc;
      end else if (out_valid) begin
        held = 1'b1;
        hd = out_data; ha = 32'(out_addr); hl = 32'(out_last);
      end
      step();
      start = 1'b0;
      cyc++;
    end
    chk({tag, " done seen"},       32'(done_cyc >= 0),      32'd1);
    chk({tag, " first valid cyc"}, 32'(first_v),            32'd3);
    chk({tag, " done after last"}, 32'(done_cyc - hs_cyc),  32'd1);
    chk({tag, " stall coverage"},  32'(stall_bad),          32'd0);
    chk({tag, " beat stability"},  32'(unstable),           32'd0);
    step();
    chk({tag, " done width"},      32'(done),               32'd0);
    chk({tag, " busy drop"},       32'(busy),               32'd0);
    chk({tag, " stall drop"},      32'(stall_req),          32'd0);
    extra_done = 0; extra_busy = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) extra_done++;
      if (busy) extra_busy++;
    end
    chk({tag, " no extra done"},   32'(extra_done),         32'd0);
    chk({tag, " stays idle"},      32'(extra_busy),         32'd0);
    chk_beats(tag);
  endtask

  initial begin
    int cyc, n_done;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < NR; i++) regs[i] = 32'(i) * 32'h01010101;
    #12;
    chk_idle_outputs("reset");
    chk("reset out_data", out_data,        32'd0);
    chk("reset out_addr", 32'(out_addr),   32'd0);
    chk("reset out_last", 32'(out_last),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_dump(0, -1, "full");
    run_dump(1, -1, "backpressure");

    // abort while a beat is held
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (cyc < 500 && !(out_valid && out_addr == AW'(10))) begin
      step();
      cyc++;
    end
    chk("abort reach idx10", 32'(cyc < 500), 32'd1);
    out_ready = 1'b0;
    step();
    step();
    chk("abort held valid", 32'(out_valid), 32'd1);
    chk("abort held addr",  32'(out_addr),  32'd10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle_outputs("abort");
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || busy) n_done++;
    end
    chk("abort quiet", 32'(n_done), 32'd0);
    run_dump(0, -1, "after abort");

    // abort and start together in IDLE
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start+abort busy", 32'(busy), 32'd0);

    run_dump(0, 5, "restart ignored");

    // async reset in LOAD at idx 20
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (cyc < 500 && !(busy && !out_valid && rd_addr == AW'(20))) begin
      step();
      cyc++;
    end
    chk("reset reach load20", 32'(cyc < 500), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    chk("midreset out_data", out_data,      32'd0);
    chk("midreset out_addr", 32'(out_addr), 32'd0);
    chk("midreset out_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_dump(0, -1, "after reset");

    // identity preload: XOR of 0..31 is zero
    for (int i = 0; i < NR; i++) regs[i] = 32'(i);
    run_dump(0, -1, "identity");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reg_dump_unit.md
Name: reg_dump_unit

Overview:
Reads all architectural registers through a register-file read port and streams them out as a valid/ready beat sequence. It is used for debug snapshot and end-of-test comparison of the MIPS multi-cycle core. While the dump runs, it asserts a stall request so the core issues no register writes. The register-file read port is combinational: address in, data out in the same cycle.

Parameters:
NUM_REGS, 32, number of registers dumped (indices 0..NUM_REGS-1); legal range 2..32.
ADDR_W, 5, register index width.
DATA_W, 32, register data width.

Ports:
clk  input  1  system clock, all state changes on its rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
abort  input  1  synchronous cancel; takes priority over every other input.
stall_req  output  1  asks the core to freeze; high while state is not IDLE.
busy  output  1  high while state is not IDLE.
done  output  1  one-cycle pulse after the final beat is accepted.
rd_addr  output  ADDR_W  read address to the register-file read port.
rd_data  input  DATA_W  combinational read data from the register file.
out_valid  output  1  a beat is presented.
out_ready  input  1  sink accepts the beat.
out_data  output  DATA_W  beat payload.
out_addr  output  ADDR_W  register index of the payload.
out_last  output  1  marks the final beat of a dump.

Behaviour:
- Reset (async, rst_n low): state=IDLE, idx=0, stall_req=0, busy=0, done=0, out_valid=0, out_data=0, out_addr=0, out_last=0, rd_addr=0.
- States: IDLE, ARM, LOAD, SEND, DONE.
- IDLE: start=1 moves to ARM; idx cleared to 0. Otherwise stay in IDLE.
- ARM: lasts one cycle so the core can reach its stall point. stall_req is already high here. Next state is LOAD.
- LOAD: rd_addr=idx. At the clock edge, out_data<=rd_data, out_addr<=idx, out_last<=(idx==NUM_REGS-1). Next state is SEND.
- SEND: out_valid=1. out_data, out_addr and out_last stay stable until out_valid&&out_ready.
  - On handshake with out_last=0: idx<=idx+1, go to LOAD.
  - On handshake with out_last=1: go to DONE.
  - While out_ready=0: hold in SEND indefinitely.
- DONE: done=1 for exactly one cycle; out_valid=0; next state is IDLE. busy and stall_req drop when IDLE is entered.
- Throughput: one beat per 2 cycles when out_ready is held high. Latency from the start edge to the first out_valid is 3 cycles (ARM, LOAD, SEND).
- rd_addr outside LOAD holds the last driven value; it has no effect on the register file.
- start while busy is ignored; a dump is never queued or restarted.
- abort=1 in any state: next state is IDLE, out_valid drops immediately, no done pulse, idx=0. This is the only case where an unaccepted beat may be withdrawn. abort and start in the same IDLE cycle: stay in IDLE.
- Register 0 is dumped like any other index, whatever value the register file returns.
- Exactly NUM_REGS beats per completed dump, in ascending index order. No wrap-around past NUM_REGS-1.
- Async reset mid-dump clears everything as above. The sink must discard any partial sequence.

Optional Feature:
DUMP_CHECKSUM_EN
- Defined:
  - An XOR accumulator is cleared at ARM and folds in each accepted data beat.
  - After the register-(NUM_REGS-1) beat is accepted, one extra beat is sent with out_data=XOR of all dumped values, out_addr=0, out_last=1.
  - On that path the register beats carry out_last=0. The checksum beat follows the same SEND hold rules.
  - Then DONE. Total beats = NUM_REGS+1.
- Undefined: no accumulator, no extra beat; behaviour exactly as above.

Test Plan:
- Register file preloaded with reg[i]=i*0x01010101, out_ready=1, pulse start → 32 beats in order; beat k has out_data=k*0x01010101, out_addr=k; out_last only on k=31; done 1 cycle after beat 31; stall_req high from the cycle after start through DONE; first out_valid 3 cycles after start.
- Same preload, out_ready toggled 0,0,1 repeatedly → each beat held stable over stall cycles; no beat lost or duplicated; 32 beats total.
- abort asserted in SEND at idx=10 with out_ready=0 → out_valid=0 next cycle, busy=0, no done; a following start dumps from index 0.
- start pulsed again at idx=5 → ignored; exactly 32 beats, one done.
- rst_n pulled low during LOAD at idx=20 → all outputs 0 immediately, state IDLE; release and start → full dump from index 0.
- With DUMP_CHECKSUM_EN, reg[i]=i → 33 beats; beat 32 has out_data=0x00000000 (XOR 0..31), out_last=1; beat 31 has out_last=0.
